// File: rtl/alu_param.sv
// alu_param: multi-cycle parameterised ALU.
// Single-cycle logic/arithmetic/shift operations finish one edge after the
// accepting edge. MUL (shift-add) and DIV (restoring) run W iterations in
// RUN, then report on the following edge. Results, complement and flags are
// registered and hold between completions.
module alu_param #(
  parameter int W  = 16,
  parameter int PW = $clog2(W)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           bgn,
  input  logic [3:0]     control,
  input  logic [PW-1:0]  pos,
  input  logic [W-1:0]   nr1,
  input  logic [W-1:0]   nr2,
  output logic [2*W-1:0] outbus,
  output logic [2*W-1:0] neg,
  output logic           carry_next,
  output logic           borrow_next,
  output logic           err,
  output logic           busy,
  output logic           fin
);

  localparam int CW = $clog2(W);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] OP_DIV = 4'd0;
  localparam logic [3:0] OP_MUL = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     op_q, op_d;
  logic [PW-1:0]  pos_q, pos_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  // MUL: {partial product high, multiplier/low bits}; DIV: {remainder, quotient}
  logic [2*W-1:0] work_q, work_d;
  logic [2*W-1:0] outbus_q, outbus_d;
  logic [2*W-1:0] neg_q, neg_d;
  logic           carry_q, carry_d;
  logic           borrow_q, borrow_d;
  logic           err_q, err_d;
  logic           busy_q, busy_d;
  logic           fin_q, fin_d;

  logic [W:0]     sum_s;
  logic [W:0]     mul_sum_s;
  logic [W:0]     div_shift_s;
  logic [W-1:0]   div_diff_s;
  logic           div_ge_s;
  logic [2*W-1:0] res_s;
  logic           carry_s;
  logic           borrow_s;
  logic           err_s;

  assign sum_s       = {1'b0, a_q} + {1'b0, b_q};
  assign mul_sum_s   = {1'b0, work_q[2*W-1:W]} + (work_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});
  assign div_shift_s = {work_q[2*W-1:W], work_q[W-1]};
  assign div_ge_s    = (div_shift_s >= {1'b0, b_q});
  // When the trial subtraction succeeds the difference always fits in W bits.
  assign div_diff_s  = div_shift_s[W-1:0] - b_q;

  // Final result and flags for the latched opcode, consumed in DONE.
  always_comb begin
    res_s    = {(2*W){1'b0}};
    carry_s  = 1'b0;
    borrow_s = 1'b0;
    err_s    = 1'b0;
    case (op_q)
      OP_DIV: begin
        res_s = {work_q[W-1:0], work_q[2*W-1:W]};
        err_s = (b_q == {W{1'b0}});
      end
      OP_MUL: res_s = work_q;
      OP_SUB: begin
        res_s    = {{W{1'b0}}, a_q - b_q};
        borrow_s = (a_q < b_q);
      end
      OP_ADD: begin
        res_s   = {{W{1'b0}}, sum_s[W-1:0]};
        carry_s = sum_s[W];
      end
      OP_OR:  res_s = {{W{1'b0}}, a_q | b_q};
      OP_AND: res_s = {{W{1'b0}}, a_q & b_q};
      OP_XOR: res_s = {{W{1'b0}}, a_q ^ b_q};
      // Shift amounts of W or more shift every bit out, giving zero.
      OP_SHL: res_s = {{W{1'b0}}, a_q << pos_q};
      OP_SHR: res_s = {{W{1'b0}}, a_q >> pos_q};
      default: err_s = 1'b1;
    endcase
  end

  // Control FSM, operand capture and iterative MUL/DIV datapath.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    pos_d    = pos_q;
    a_d      = a_q;
    b_d      = b_q;
    work_d   = work_q;
    outbus_d = outbus_q;
    neg_d    = neg_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    err_d    = err_q;
    busy_d   = busy_q;
    fin_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bgn) begin
          op_d   = control;
          pos_d  = pos;
          a_d    = nr1;
          b_d    = nr2;
          busy_d = 1'b1;
          cnt_d  = {CW{1'b0}};
          if (control == OP_MUL) begin
            work_d  = {{W{1'b0}}, nr2};
            state_d = ST_RUN;
          end else if (control == OP_DIV) begin
            work_d  = {{W{1'b0}}, nr1};
            state_d = ST_RUN;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (op_q == OP_MUL) begin
          work_d = {mul_sum_s, work_q[W-1:1]};
        end else if (div_ge_s) begin
          work_d = {div_diff_s, work_q[W-2:0], 1'b1};
        end else begin
          work_d = {div_shift_s[W-1:0], work_q[W-2:0], 1'b0};
        end
        if (cnt_q == CW'(W-1)) begin
          cnt_d   = {CW{1'b0}};
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        outbus_d = res_s;
        neg_d    = ~res_s;
        carry_d  = carry_s;
        borrow_d = borrow_s;
        err_d    = err_s;
        busy_d   = 1'b0;
        fin_d    = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CW{1'b0}};
      op_q     <= 4'd0;
      pos_q    <= {PW{1'b0}};
      a_q      <= {W{1'b0}};
      b_q      <= {W{1'b0}};
      work_q   <= {(2*W){1'b0}};
      outbus_q <= {(2*W){1'b0}};
      neg_q    <= {(2*W){1'b1}};
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      fin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      pos_q    <= pos_d;
      a_q      <= a_d;
      b_q      <= b_d;
      work_q   <= work_d;
      outbus_q <= outbus_d;
      neg_q    <= neg_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      fin_q    <= fin_d;
    end
  end

  assign outbus      = outbus_q;
  assign neg         = neg_q;
  assign carry_next  = carry_q;
  assign borrow_next = borrow_q;
  assign err         = err_q;
  assign busy        = busy_q;
  assign fin         = fin_q;

endmodule

// File: tb/tb_alu_param.sv
// Directed bench for alu_param (W=16) with a result scoreboard.
module tb_alu_param;
  localparam int W  = 16;
  localparam int PW = 4;

  typedef struct packed {
    logic [31:0] ob;
    logic        c;
    logic        b;
    logic        e;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bgn = 1'b0;
  logic [3:0]    control = 4'd0;
  logic [PW-1:0] pos = 4'd0;
  logic [W-1:0]  nr1 = 16'h0;
  logic [W-1:0]  nr2 = 16'h0;
  logic [2*W-1:0] outbus, neg;
  logic carry_next, borrow_next, err, busy, fin;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sb_q[$];
  logic [31:0] last_ob = 32'h0;
  logic        prev_fin = 1'b0;

  alu_param #(.W(W), .PW(PW)) dut (
    .clk(clk), .rst(rst), .bgn(bgn), .control(control), .pos(pos),
    .nr1(nr1), .nr2(nr2), .outbus(outbus), .neg(neg),
    .carry_next(carry_next), .borrow_next(borrow_next),
    .err(err), .busy(busy), .fin(fin)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] ctl, input logic [15:0] a,
                                 input logic [15:0] b, input logic [3:0] p);
    exp_t r;
    logic [16:0] s;
    r = '0;
    case (ctl)
      4'd0: begin
        if (b == 16'h0) begin
          r.ob = {16'hFFFF, a};
          r.e  = 1'b1;
        end else begin
          r.ob = {a / b, a % b};
        end
      end
      4'd1: r.ob = {16'h0, a} * {16'h0, b};
      4'd2: begin r.ob = {16'h0, a - b}; r.b = (a < b); end
      4'd3: begin s = {1'b0, a} + {1'b0, b}; r.ob = {16'h0, s[15:0]}; r.c = s[16]; end
      4'd4: r.ob = {16'h0, a | b};
      4'd5: r.ob = {16'h0, a & b};
      4'd6: r.ob = {16'h0, a ^ b};
      4'd7: r.ob = {16'h0, a << p};
      4'd8: r.ob = {16'h0, a >> p};
      default: r.e = 1'b1;
    endcase
    return r;
  endfunction

  // Scoreboard: every fin pulse pops and checks one expected result.
  always @(negedge clk) begin
    exp_t e;
    if (fin) begin
      chk("fin_expected", 64'(sb_q.size() != 0), 64'd1);
      chk("fin_one_cycle", {63'd0, prev_fin}, 64'd0);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("outbus", {32'h0, outbus}, {32'h0, e.ob});
        chk("neg", {32'h0, neg}, {32'h0, ~e.ob});
        chk("flags_cbe", {61'd0, carry_next, borrow_next, err}, {61'd0, e.c, e.b, e.e});
        last_ob <= e.ob;
      end
    end
    prev_fin <= fin;
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_outbus"}, {32'h0, outbus}, 64'h0);
    chk({tag, "_neg"}, {32'h0, neg}, 64'hFFFF_FFFF);
    chk({tag, "_ctl"}, {59'd0, carry_next, borrow_next, err, busy, fin}, 64'd0);
  endtask

  task automatic issue(input logic [3:0] ctl, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] p, input bit push);
    control = ctl;
    nr1     = a;
    nr2     = b;
    pos     = p;
    bgn     = 1'b1;
    if (push) sb_q.push_back(model(ctl, a, b, p));
    @(posedge clk);
  endtask

  task automatic run_op(input logic [3:0] ctl, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] p, input int exp_lat, input bit inject);
    int lat;
    issue(ctl, a, b, p, 1'b1);
    #1;
    bgn = 1'b0;
    chk("busy_on_accept", {63'd0, busy}, 64'd1);
    lat = 0;
    while (fin !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (inject && lat == 5) begin
        chk("hold_during_run", {32'h0, outbus}, {32'h0, last_ob});
        control = 4'd3;
        nr1     = 16'h0001;
        nr2     = 16'h0002;
        bgn     = 1'b1;
        @(posedge clk);
        #1;
        lat++;
        bgn = 1'b0;
        chk("busy_ignores_bgn", {63'd0, busy}, 64'd1);
      end
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("busy_clear_at_fin", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    bit saw_fin;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b0;

    // First op accepted on the first edge with rst low; all back-to-back.
    run_op(4'd3, 16'hFFFF, 16'h0001, 4'd0, 1, 1'b0);
    run_op(4'd2, 16'h0003, 16'h0005, 4'd0, 1, 1'b0);
    run_op(4'd7, 16'h0001, 16'h0000, 4'd15, 1, 1'b0);
    run_op(4'd8, 16'h8000, 16'h0000, 4'd15, 1, 1'b0);
    run_op(4'd4, 16'hA5A5, 16'h0FF0, 4'd0, 1, 1'b0);
    run_op(4'd5, 16'hA5A5, 16'h0FF0, 4'd0, 1, 1'b0);
    run_op(4'd6, 16'hA5A5, 16'h0FF0, 4'd0, 1, 1'b0);
    run_op(4'd1, 16'hFFFF, 16'hFFFF, 4'd0, 17, 1'b0);
    run_op(4'd1, 16'h1234, 16'h5678, 4'd0, 17, 1'b1);
    run_op(4'd0, 16'h0064, 16'h0007, 4'd0, 17, 1'b0);
    run_op(4'd0, 16'h0064, 16'h0000, 4'd0, 17, 1'b0);
    run_op(4'd3, 16'h7FFF, 16'h0001, 4'd0, 1, 1'b0);

    // Outputs hold across idle cycles.
    repeat (3) @(negedge clk);
    chk("hold_idle", {32'h0, outbus}, 64'h0000_8000);

    // Reset at edge N+8 of a DIV aborts it without a fin pulse.
    issue(4'd0, 16'h0064, 16'h0007, 4'd0, 1'b0);
    #1;
    bgn = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset("abort");
    saw_fin = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (fin) saw_fin = 1'b1;
    end
    chk("no_fin_after_abort", {63'd0, saw_fin}, 64'd0);

    run_op(4'd0, 16'hFFFF, 16'h0010, 4'd0, 17, 1'b0);
    run_op(4'd12, 16'h1234, 16'h5678, 4'd3, 1, 1'b0);
    run_op(4'd3, 16'h1234, 16'h0001, 4'd0, 1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_param.md
ALU_PARAM -- requirements
Module: alu_param

Interface
REQ-001 Parameter W, default 16, meaning operand width; legal values 4..32.
REQ-002 Parameter PW, default $clog2(W), meaning width of the shift-amount port.
REQ-003 clk  input  1  meaning single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  meaning synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 bgn  input  1  meaning start request; accepted only while busy=0.
REQ-006 control  input  4  meaning opcode: 0 DIV, 1 MUL, 2 SUB, 3 ADD, 4 OR, 5 AND, 6 XOR, 7 SHL, 8 SHR; 9..15 illegal.
REQ-007 pos  input  PW  meaning shift amount for SHL/SHR.
REQ-008 nr1  input  W  meaning operand A (dividend, minuend).
REQ-009 nr2  input  W  meaning operand B (divisor, subtrahend).
REQ-010 outbus  output  2W  meaning registered result.
REQ-011 neg  output  2W  meaning registered bitwise complement of outbus.
REQ-012 carry_next  output  1  meaning ADD carry-out.
REQ-013 borrow_next  output  1  meaning SUB borrow-out.
REQ-014 err  output  1  meaning illegal opcode or divide-by-zero on the last operation.
REQ-015 busy  output  1  meaning operation in progress; bgn ignored.
REQ-016 fin  output  1  meaning one-cycle pulse; outbus/flags updated on this same edge.

Function
REQ-017 States: IDLE, RUN, DONE; IDLE --bgn--> RUN (MUL/DIV) or DONE (all other opcodes); RUN --counter=W-1--> DONE; DONE --> IDLE unconditionally.
REQ-018 On the accepting edge N: control, pos, nr1, nr2 latched; busy=1 from edge N; later input changes have no effect on the operation.
REQ-019 Single-cycle ops (2..8, illegal): result, flags, fin=1 written at edge N+1; busy=0 from edge N+1.
REQ-020 MUL/DIV: W iterations on edges N+1..N+W; result, fin=1 written at edge N+W+1; busy=0 from that edge.
REQ-021 fin high exactly one cycle; bgn=1 while fin=1 is accepted (back-to-back ops, no idle gap).
REQ-022 ADD: outbus={W'b0, (A+B) mod 2^W}, carry_next=bit W of A+B; borrow_next=0.
REQ-023 SUB: outbus={W'b0, (A-B) mod 2^W}, borrow_next=1 iff A<B unsigned; carry_next=0.
REQ-024 OR/AND/XOR: outbus={W'b0, A op B}; carry_next=borrow_next=0.
REQ-025 SHL/SHR: logical shift of A by pos (zero fill); pos>=W gives 0; upper W bits of outbus 0.
REQ-026 MUL: unsigned shift-add, outbus=A*B full 2W bits.
REQ-027 DIV: unsigned restoring, outbus[2W-1:W]=A/B, outbus[W-1:0]=A%B.
REQ-028 DIV with B=0: quotient all ones, remainder=A, err=1; still W+1 cycle latency.
REQ-029 Illegal opcode: outbus=0, err=1, single-cycle latency.
REQ-030 err cleared to 0 on every legal non-zero-divisor completion; carry_next/borrow_next 0 for every op other than ADD/SUB.
REQ-031 neg=~outbus, updated on the same edge as outbus, never a cycle later.
REQ-032 outbus, neg, flags hold their values between completions; not disturbed during RUN.
REQ-033 bgn=1 while busy=1: ignored, no queuing, running op unaffected.

Reset
REQ-034 rst=1 at an edge: state=IDLE, counter=0, outbus=0, neg=all ones, carry_next=borrow_next=err=busy=fin=0.
REQ-035 rst dominates bgn on the same edge; reset during RUN aborts the op with no fin pulse.
REQ-036 First bgn accepted on the first edge with rst=0.

Verification (W=16)
REQ-037 ADD nr1=FFFF nr2=0001 -> after 1 cycle outbus=00000000, carry_next=1, fin pulse, neg=FFFFFFFF.
REQ-038 SUB nr1=0003 nr2=0005 -> outbus=0000FFFE, borrow_next=1; SHL nr1=0001 pos=15 -> outbus=00008000.
REQ-039 MUL nr1=FFFF nr2=FFFF -> busy for 17 cycles, fin at edge N+17, outbus=FFFE0001.
REQ-040 DIV nr1=0064 nr2=0007 -> outbus=000E0002, err=0; DIV nr2=0 -> outbus=FFFF0064 (nr1=0064), err=1.
REQ-041 bgn pulsed mid-MUL with new operands -> ignored, original product delivered; bgn during fin -> new op accepted.
REQ-042 rst at edge N+8 of a DIV -> no fin, all outputs at reset values, next bgn runs normally; control=12 -> outbus=0, err=1.
